// File: rtl/word_readout.sv
// Plays back a stored word one character at a time: each character is fetched
// from the buffer, then presented on char_out for STEP_CYCLES cycles.
module word_readout #(
  parameter int unsigned CHAR_W      = 5,
  parameter int unsigned STEP_CYCLES = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic [2:0]        word_len,
  output logic [2:0]        rd_addr,
  input  logic [CHAR_W-1:0] rd_data,
  output logic [CHAR_W-1:0] char_out,
  output logic              char_valid,
  output logic              busy,
  output logic              done
);

  localparam int unsigned ADDR_W  = 3;
  localparam int unsigned TIMER_W = 8;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] FETCH = 2'd1;
  localparam logic [1:0] SHOW  = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  logic [1:0]         state, state_nxt;
  logic [ADDR_W-1:0]  index, index_nxt;
  logic [ADDR_W-1:0]  len, len_nxt;
  logic [ADDR_W-1:0]  rd_addr_nxt;
  logic [TIMER_W-1:0] timer, timer_nxt;
  logic [CHAR_W-1:0]  char_out_nxt;
  logic               char_valid_nxt;
  logic               done_nxt;

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      index      <= '0;
      len        <= '0;
      timer      <= '0;
      rd_addr    <= '0;
      char_out   <= '0;
      char_valid <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      state      <= state_nxt;
      index      <= index_nxt;
      len        <= len_nxt;
      timer      <= timer_nxt;
      rd_addr    <= rd_addr_nxt;
      char_out   <= char_out_nxt;
      char_valid <= char_valid_nxt;
      busy       <= (state_nxt != IDLE);
      done       <= done_nxt;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_nxt      = state;
    index_nxt      = index;
    len_nxt        = len;
    timer_nxt      = timer;
    rd_addr_nxt    = rd_addr;
    char_out_nxt   = char_out;
    char_valid_nxt = char_valid;
    done_nxt       = 1'b0;

    if ((state != IDLE) && abort) begin
      state_nxt      = IDLE;
      index_nxt      = '0;
      timer_nxt      = '0;
      rd_addr_nxt    = '0;
      char_out_nxt   = '0;
      char_valid_nxt = 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start && !abort) begin
            if (word_len != 3'd0) begin
              len_nxt     = word_len;
              index_nxt   = '0;
              rd_addr_nxt = '0;
              state_nxt   = FETCH;
            end else begin
              state_nxt = DONE;
              done_nxt  = 1'b1;
            end
          end
        end
        FETCH: begin
          char_out_nxt   = rd_data;
          char_valid_nxt = 1'b1;
          timer_nxt      = TIMER_W'(STEP_CYCLES - 1);
          state_nxt      = SHOW;
        end
        SHOW: begin
          if (timer != '0) begin
            timer_nxt = TIMER_W'(timer - TIMER_W'(1));
          end else if (index != ADDR_W'(len - ADDR_W'(1))) begin
            index_nxt      = ADDR_W'(index + ADDR_W'(1));
            rd_addr_nxt    = ADDR_W'(rd_addr + ADDR_W'(1));
            char_valid_nxt = 1'b0;
            state_nxt      = FETCH;
          end else begin
            char_valid_nxt = 1'b0;
            done_nxt       = 1'b1;
            state_nxt      = DONE;
          end
        end
        DONE: begin
          state_nxt = IDLE;
        end
        default: begin
          state_nxt = IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_word_readout.sv
// Bench for word_readout: two instances (STEP_CYCLES 4 and 1) share stimulus and
// are checked every cycle against a schedule-based model, plus literal pins.
module tb_word_readout;

  localparam int unsigned CW = 5;
  localparam int unsigned NI = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic          abort;
  logic [2:0]    word_len;
  logic [CW-1:0] buffer [8];

  logic [2:0]    rd_addr    [NI];
  logic [CW-1:0] rd_data    [NI];
  logic [CW-1:0] char_out   [NI];
  logic          char_valid [NI];
  logic          busy       [NI];
  logic          done       [NI];

  int n_tests = 0;
  int n_fail  = 0;

  // Model state: t = edges since the accepted start of the current playback
  logic          m_act   [NI];
  int            m_t     [NI];
  int            m_len   [NI];
  logic [CW-1:0] m_cout  [NI];
  logic [2:0]    m_addr  [NI];
  logic          m_valid [NI];
  logic          m_busy  [NI];
  logic          m_done  [NI];

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    assign rd_data[g] = buffer[rd_addr[g]];
    word_readout #(
      .CHAR_W      (CW),
      .STEP_CYCLES ((g == 0) ? 4 : 1)
    ) u_dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .abort      (abort),
      .word_len   (word_len),
      .rd_addr    (rd_addr[g]),
      .rd_data    (rd_data[g]),
      .char_out   (char_out[g]),
      .char_valid (char_valid[g]),
      .busy       (busy[g]),
      .done       (done[g])
    );
  end

  function automatic int step_of(input int i);
    return (i == 0) ? 4 : 1;
  endfunction

  task automatic chk(input string nm, input int i, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s[%0d] at %0t: got %0d expected %0d", nm, i, $time, got, exp);
    end
  endtask

  // Character k occupies edges 1+P*k .. P*(k+1) with P = STEP_CYCLES+1:
  // captured at the first, shown for STEP_CYCLES, gap at the last.
  task automatic model_update();
    for (int i = 0; i < NI; i++) begin
      int s;
      int p;
      int k;
      int ph;
      int a;
      s = step_of(i);
      p = s + 1;
      if (reset) begin
        m_act[i] = 1'b0; m_t[i] = 0; m_len[i] = 0; m_cout[i] = '0; m_addr[i] = '0;
        m_valid[i] = 1'b0; m_busy[i] = 1'b0; m_done[i] = 1'b0;
      end else if (m_act[i] && abort) begin
        m_act[i] = 1'b0; m_cout[i] = '0; m_addr[i] = '0;
        m_valid[i] = 1'b0; m_busy[i] = 1'b0; m_done[i] = 1'b0;
      end else if (m_act[i]) begin
        m_t[i] = m_t[i] + 1;
        if (m_t[i] > p * m_len[i]) begin
          m_act[i] = 1'b0; m_valid[i] = 1'b0; m_busy[i] = 1'b0; m_done[i] = 1'b0;
        end else begin
          k  = (m_t[i] - 1) / p;
          ph = (m_t[i] - 1) % p;
          if (ph == 0) m_cout[i] = buffer[k];
          m_valid[i] = (ph < s);
          m_done[i]  = (m_t[i] == p * m_len[i]);
          a = m_t[i] / p;
          if (a > m_len[i] - 1) a = m_len[i] - 1;
          m_addr[i] = 3'(a);
        end
      end else begin
        m_done[i] = 1'b0;
        if (start && !abort) begin
          m_len[i]  = int'(word_len);
          m_t[i]    = 0;
          m_act[i]  = 1'b1;
          m_busy[i] = 1'b1;
          m_done[i] = (word_len == 3'd0);
          if (word_len != 3'd0) m_addr[i] = '0;
        end
      end
    end
  endtask

  // One clock: model at the rising edge, compare on the falling edge
  task automatic step();
    @(posedge clk);
    model_update();
    @(negedge clk);
    for (int i = 0; i < NI; i++) begin
      chk("char_out",   i, 32'(char_out[i]),   32'(m_cout[i]));
      chk("char_valid", i, 32'(char_valid[i]), 32'(m_valid[i]));
      chk("busy",       i, 32'(busy[i]),       32'(m_busy[i]));
      chk("done",       i, 32'(done[i]),       32'(m_done[i]));
      chk("rd_addr",    i, 32'(rd_addr[i]),    32'(m_addr[i]));
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    start = 1'b0;
    abort = 1'b0;
    while ((m_busy[0] || m_busy[1]) && n < 200) begin
      step();
      n++;
    end
    chk("idle_timeout", 0, 32'(busy[0] | busy[1]), 32'd0);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; abort = 1'b0; word_len = 3'd0;
    for (int i = 0; i < 8; i++) buffer[i] = '0;
    for (int i = 0; i < NI; i++) begin
      m_act[i] = 1'b0; m_t[i] = 0; m_len[i] = 0; m_cout[i] = '0; m_addr[i] = '0;
      m_valid[i] = 1'b0; m_busy[i] = 1'b0; m_done[i] = 1'b0;
    end
    step();
    step();
    chk("rst_busy", 0, 32'(busy[0]), 32'd0);
    chk("rst_char_out", 0, 32'(char_out[0]), 32'd0);
    reset = 1'b0;
    step();

    // Word {3,7,12}; re-start with a different length while busy must be ignored
    buffer[0] = 5'd3; buffer[1] = 5'd7; buffer[2] = 5'd12;
    start = 1'b1; word_len = 3'd3;
    step();
    start = 1'b0;
    chk("a_busy_e0", 0, 32'(busy[0]), 32'd1);
    chk("a_addr_e0", 0, 32'(rd_addr[0]), 32'd0);
    for (int e = 1; e <= 16; e++) begin
      if (e == 3) begin start = 1'b1; word_len = 3'd5; end
      if (e == 6) begin start = 1'b0; word_len = 3'd1; end
      step();
      case (e)
        1:  begin chk("a_char0", 0, 32'(char_out[0]), 32'd3); chk("a_valid_e1", 0, 32'(char_valid[0]), 32'd1); end
        4:  chk("a_valid_e4", 0, 32'(char_valid[0]), 32'd1);
        5:  begin chk("a_gap_e5", 0, 32'(char_valid[0]), 32'd0); chk("a_hold_e5", 0, 32'(char_out[0]), 32'd3); end
        6:  chk("a_char1", 0, 32'(char_out[0]), 32'd7);
        11: chk("a_char2", 0, 32'(char_out[0]), 32'd12);
        15: begin chk("a_done_e15", 0, 32'(done[0]), 32'd1); chk("a_busy_e15", 0, 32'(busy[0]), 32'd1); end
        16: begin
          chk("a_done_e16", 0, 32'(done[0]), 32'd0);
          chk("a_busy_e16", 0, 32'(busy[0]), 32'd0);
          chk("a_hold_e16", 0, 32'(char_out[0]), 32'd12);
        end
        default: ;
      endcase
    end
    wait_idle();

    // Empty word
    start = 1'b1; word_len = 3'd0;
    step();
    start = 1'b0;
    chk("b_done", 0, 32'(done[0]), 32'd1);
    chk("b_busy", 0, 32'(busy[0]), 32'd1);
    chk("b_valid", 0, 32'(char_valid[0]), 32'd0);
    step();
    chk("b_busy_after", 0, 32'(busy[0]), 32'd0);
    wait_idle();

    // Seven characters, STEP_CYCLES=1 instance
    for (int i = 0; i < 8; i++) buffer[i] = CW'($urandom);
    start = 1'b1; word_len = 3'd7;
    step();
    start = 1'b0;
    for (int e = 1; e <= 15; e++) begin
      step();
      chk("c_addr_not7", 1, 32'(rd_addr[1] == 3'd7), 32'd0);
      if (e == 7)  chk("c_addr_e7", 1, 32'(rd_addr[1]), 32'd3);
      if (e == 13) begin
        chk("c_addr_e13", 1, 32'(rd_addr[1]), 32'd6);
        chk("c_char6", 1, 32'(char_out[1]), 32'(buffer[6]));
      end
      if (e == 14) chk("c_done_e14", 1, 32'(done[1]), 32'd1);
    end
    wait_idle();

    // Abort during the second character, then replay from address 0
    buffer[0] = 5'd3; buffer[1] = 5'd7; buffer[2] = 5'd12;
    start = 1'b1; word_len = 3'd3;
    step();
    start = 1'b0;
    for (int e = 1; e <= 7; e++) step();
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("d_valid", 0, 32'(char_valid[0]), 32'd0);
    chk("d_char_out", 0, 32'(char_out[0]), 32'd0);
    chk("d_busy", 0, 32'(busy[0]), 32'd0);
    chk("d_addr", 0, 32'(rd_addr[0]), 32'd0);
    for (int e = 0; e < 12; e++) begin
      step();
      chk("d_no_done", 0, 32'(done[0]), 32'd0);
    end
    start = 1'b1; word_len = 3'd3;
    step();
    start = 1'b0;
    chk("d_replay_addr", 0, 32'(rd_addr[0]), 32'd0);
    step();
    chk("d_replay_char", 0, 32'(char_out[0]), 32'd3);
    wait_idle();

    // Reset in FETCH with start held, then abort+start together in IDLE
    start = 1'b1; word_len = 3'd3;
    step();
    reset = 1'b1;
    step();
    chk("e_busy", 0, 32'(busy[0]), 32'd0);
    chk("e_char_out", 0, 32'(char_out[0]), 32'd0);
    chk("e_valid", 0, 32'(char_valid[0]), 32'd0);
    chk("e_done", 0, 32'(done[0]), 32'd0);
    chk("e_addr", 0, 32'(rd_addr[0]), 32'd0);
    step();
    reset = 1'b0; start = 1'b0;
    step();
    chk("e_idle", 0, 32'(busy[0]), 32'd0);
    abort = 1'b1; start = 1'b1; word_len = 3'd3;
    step();
    chk("e_abort_wins0", 0, 32'(busy[0]), 32'd0);
    chk("e_abort_wins1", 1, 32'(busy[1]), 32'd0);
    abort = 1'b0; start = 1'b0;
    step();

    // Randomized traffic
    for (int c = 0; c < 600; c++) begin
      start    = ($urandom_range(0, 7) == 0);
      abort    = ($urandom_range(0, 39) == 0);
      reset    = ($urandom_range(0, 199) == 0);
      word_len = 3'($urandom_range(0, 7));
      buffer[$urandom_range(0, 7)] = CW'($urandom);
      step();
    end
    reset = 1'b0;
    wait_idle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/word_readout.md
WORD_READOUT -- requirements
Module: word_readout

Interface
REQ-001 SHALL have parameter CHAR_W, default 5, giving the character code width in bits.
REQ-002 SHALL have parameter STEP_CYCLES, default 4, giving the number of cycles each character is presented; legal range 1..255.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port start, input, 1 bit: request playback of the stored word; sampled only in IDLE.
REQ-006 SHALL have port abort, input, 1 bit: cancel playback; driven from the star key.
REQ-007 SHALL have port word_len, input, 3 bits: number of stored characters, 0..7; sampled on the accepted start.
REQ-008 SHALL have port rd_addr, output, 3 bits: character buffer read address.
REQ-009 SHALL have port rd_data, input, CHAR_W bits: buffer data, valid one cycle after rd_addr changes.
REQ-010 SHALL have port char_out, output, CHAR_W bits: the character currently presented.
REQ-011 SHALL have port char_valid, output, 1 bit: char_out is being presented.
REQ-012 SHALL have port busy, output, 1 bit: high in any state other than IDLE.
REQ-013 SHALL have port done, output, 1 bit: one-cycle completion pulse.

Function
REQ-014 SHALL implement the states IDLE, FETCH, SHOW and DONE, with all outputs registered.
REQ-015 IDLE, start=1 and word_len!=0: SHALL latch word_len as LEN, set index=0 and rd_addr=0, and go to FETCH.
REQ-016 IDLE, start=1 and word_len=0: SHALL go to DONE without presenting any character.
REQ-017 FETCH: SHALL last exactly 1 cycle with char_valid=0, then capture rd_data into char_out, set char_valid=1, load timer=STEP_CYCLES-1, and go to SHOW.
REQ-018 SHOW with timer!=0: SHALL decrement timer and hold char_out.
REQ-019 SHOW with timer=0 and index<LEN-1: SHALL increment index and rd_addr, clear char_valid, and go to FETCH.
REQ-020 SHOW with timer=0 and index=LEN-1: SHALL clear char_valid and go to DONE.
REQ-021 DONE: SHALL drive done=1 for exactly 1 cycle and then return to IDLE.
REQ-022 Timing: character k SHALL be valid for the STEP_CYCLES cycles following edges 1+(STEP_CYCLES+1)k onward, where start is sampled at edge 0.
REQ-023 Timing: done SHALL be high for the cycle after edge (STEP_CYCLES+1)*LEN.
REQ-024 SHALL ignore start while busy=1; LEN SHALL NOT change mid-playback if word_len changes.
REQ-025 abort=1 in any non-IDLE state SHALL give IDLE on the next edge: char_valid=0, done=0, rd_addr=0, char_out=0.
REQ-026 abort=1 in IDLE SHALL cause no state change.
REQ-027 abort=1 and start=1 together in IDLE: abort SHALL win and playback SHALL NOT start.
REQ-028 rd_addr SHALL never exceed LEN-1 and SHALL NOT wrap; word_len=7 SHALL read addresses 0..6.
REQ-029 char_out SHALL hold its last value after DONE until the next FETCH capture, reset, or abort.

Reset
REQ-030 reset=1 at a rising clk edge SHALL force IDLE, rd_addr=0, char_out=0, char_valid=0, busy=0, done=0, index=0, timer=0, LEN=0.
REQ-031 reset SHALL take priority over start and abort.
REQ-032 reset asserted mid-playback SHALL produce no done pulse.
REQ-033 No output SHALL change other than on a clk rising edge.

Verification
REQ-034 Bench SHALL cover: STEP_CYCLES=4, buffer {3,7,12}, start with word_len=3 -> char_out 3,7,12 each valid 4 cycles with 1-cycle gaps; done pulse after edge 15; busy high edges 0..15.
REQ-035 Bench SHALL cover: start with word_len=0 -> no char_valid; done=1 the cycle after start; busy high 1 cycle.
REQ-036 Bench SHALL cover: word_len=7, STEP_CYCLES=1 -> rd_addr steps 0..6; 7 characters; done after edge 14; rd_addr never 7.
REQ-037 Bench SHALL cover: abort during SHOW of the 2nd character -> IDLE next edge, char_valid=0, char_out=0, no done; a following start replays from address 0.
REQ-038 Bench SHALL cover: start re-asserted while busy and word_len changed mid-playback -> playback unaffected, LEN unchanged.
REQ-039 Bench SHALL cover: reset asserted in FETCH, and reset with start=1 -> all outputs zero next edge; state IDLE; no playback begins.
